// File: rtl/inverse_kinematics.sv
// inverse_kinematics -- iterative unsigned divider (radix-2 restoring, one quotient bit per clock).
//
// The block watches its operands. When either differs from the copy it last divided, it
// recomputes. A result is written only when a division finishes; the outputs never show
// partial values.
//
// Parameters
//   WIDTH    operand and result width (default 16)
//
// Ports
//   clk      system clock, rising-edge active
//   reset    asynchronous, active-high; clears the outputs and all working state
//   number   unsigned dividend
//   divisor  unsigned divisor
//   result   registered quotient (all ones when divisor == 0)
//   result2  registered remainder (equals number when divisor == 0)
//
// Build option
//   INVERSE_KINEMATICS_ROUND_EN  when defined, the quotient is rounded to nearest
//                                (2*remainder >= divisor) and saturates at all ones.
//                                The remainder output is still the truncated remainder.
//
// Latency: the outputs update WIDTH+2 rising edges after the edge at which IDLE first
// sees changed operands.

module inverse_kinematics #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] number,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result2
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Operands last captured. They are set to all ones on reset; first_q forces the first
    // computation even when the inputs happen to equal all ones.
    logic [WIDTH-1:0] shadow_num_q;
    logic [WIDTH-1:0] shadow_div_q;
    logic             first_q;

    // Working registers
    logic [WIDTH-1:0] dvd_q;   // dividend, shifted left so the MSB feeds the remainder
    logic [WIDTH-1:0] div_q;   // divisor captured for this operation
    logic [WIDTH-1:0] rem_q;   // partial remainder
    logic [WIDTH-1:0] quo_q;   // quotient, filled from the LSB end
    logic [CW-1:0]    cnt_q;   // run cycles left minus one

    logic             changed;
    logic             load;
    logic             step;
    logic             write;

    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_final;

    assign changed = first_q || (number != shadow_num_q) || (divisor != shadow_div_q);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        write   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (changed) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Whatever is on the inputs at this edge is captured. A later change
                // shows up as a shadow mismatch during RUN.
                load    = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                if (changed) begin
                    // Abandon the operation; the outputs keep their old values.
                    state_d = StLoad;
                end else begin
                    step = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                write   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    // The remainder is always below the divisor, so the shifted trial value needs one
    // extra bit. After a successful subtract the difference fits WIDTH bits again, so the
    // subtraction is done modulo 2^WIDTH. A zero divisor always "fits". The quotient then
    // fills with ones and the remainder ends up equal to the dividend, which is the
    // required divide-by-zero behaviour.
    always_comb begin
        trial    = {rem_q, dvd_q[WIDTH-1]};
        fits     = (trial >= {1'b0, div_q});
        rem_sub  = trial[WIDTH-1:0] - div_q;
        rem_next = fits ? rem_sub : trial[WIDTH-1:0];
    end

`ifdef INVERSE_KINEMATICS_ROUND_EN
    logic round_up;

    // Round half up. Skip the increment for a zero divisor and when the quotient is
    // already saturated.
    always_comb begin
        round_up  = (div_q != '0) && ({rem_q, 1'b0} >= {1'b0, div_q}) && (quo_q != '1);
        quo_final = quo_q + WIDTH'(round_up);
    end
`else
    assign quo_final = quo_q;
`endif

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_num_q <= '1;
            shadow_div_q <= '1;
            first_q      <= 1'b1;
            dvd_q        <= '0;
            div_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= '0;
            result       <= '0;
            result2      <= '0;
        end else begin
            if (load) begin
                shadow_num_q <= number;
                shadow_div_q <= divisor;
                first_q      <= 1'b0;
                dvd_q        <= number;
                div_q        <= divisor;
                rem_q        <= '0;
                quo_q        <= '0;
                cnt_q        <= CW'(WIDTH - 1);
            end
            if (step) begin
                rem_q <= rem_next;
                quo_q <= {quo_q[WIDTH-2:0], fits};
                dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                cnt_q <= cnt_q - 1'b1;
            end
            if (write) begin
                result  <= quo_final;
                result2 <= rem_q;
            end
        end
    end

endmodule

// File: tb/tb_inverse_kinematics.sv
// tb_inverse_kinematics -- directed self-checking bench for inverse_kinematics.
// Each operation is applied just after a rising edge. The outputs are then checked on
// every edge: they must hold their previous values through edge E0+17 and show the new
// quotient and remainder at edge E0+18. E0 is the first edge that sees the new operands.

module tb_inverse_kinematics;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] number;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result2;

    int unsigned vectors;
    int unsigned miscompares;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_r;

    inverse_kinematics #(
        .WIDTH(WIDTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .number (number),
        .divisor(divisor),
        .result (result),
        .result2(result2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    // Edge E0 was the last edge. Outputs hold through E0+17 and update at E0+18.
    task automatic wait_result(input string tag, input logic [WIDTH-1:0] exp_q,
                               input logic [WIDTH-1:0] exp_r);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            check({tag, " hold q"}, result, prev_q);
            check({tag, " hold r"}, result2, prev_r);
        end
        @(posedge clk);
        #1;
        check({tag, " quotient"}, result, exp_q);
        check({tag, " remainder"}, result2, exp_r);
        prev_q = exp_q;
        prev_r = exp_r;
    endtask

    // Call just after an edge. Applies operands, then steps to edge E0.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] num,
                          input logic [WIDTH-1:0] div, input logic [WIDTH-1:0] exp_q,
                          input logic [WIDTH-1:0] exp_r);
        number  = num;
        divisor = div;
        @(posedge clk);
        #1;
        check({tag, " E0 q"}, result, prev_q);
        check({tag, " E0 r"}, result2, prev_r);
        wait_result(tag, exp_q, exp_r);
    endtask

    initial begin
        logic [WIDTH-1:0] q_8_5;
        logic [WIDTH-1:0] q_50_3;
        logic [WIDTH-1:0] q_50000_123;
`ifdef INVERSE_KINEMATICS_ROUND_EN
        q_8_5       = 16'd2;
        q_50_3      = 16'd17;
        q_50000_123 = 16'd407;
`else
        q_8_5       = 16'd1;
        q_50_3      = 16'd16;
        q_50000_123 = 16'd406;
`endif
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        number      = 16'd9;
        divisor     = 16'd1;
        prev_q      = '0;
        prev_r      = '0;

        @(posedge clk);
        #1;
        check("reset q", result, 16'd0);
        check("reset r", result2, 16'd0);
        reset = 1'b0;

        // First IDLE edge after release always starts a computation.
        @(posedge clk);
        #1;
        wait_result("9/1", 16'd9, 16'd0);

        // Long idle: the outputs stay put.
        repeat (100) @(posedge clk);
        #1;
        check("idle q", result, 16'd9);
        check("idle r", result2, 16'd0);

        run_op("6/2", 16'd6, 16'd2, 16'd3, 16'd0);
        run_op("0/7", 16'd0, 16'd7, 16'd0, 16'd0);
        run_op("8/5", 16'd8, 16'd5, q_8_5, 16'd3);
        run_op("ffff/ff", 16'hFFFF, 16'h00FF, 16'd257, 16'd0);
        run_op("50000/123", 16'd50000, 16'd123, q_50000_123, 16'd62);

        // Abort: start 100/7, then switch to 50/3 in the fifth RUN cycle.
        number  = 16'd100;
        divisor = 16'd7;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            check("abort hold q", result, prev_q);
            check("abort hold r", result2, prev_r);
        end
        run_op("abort 50/3", 16'd50, 16'd3, q_50_3, 16'd2);

        run_op("1234/0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234);

        // Reset mid-RUN, asserted away from any clock edge.
        number  = 16'd200;
        divisor = 16'd9;
        repeat (8) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid reset q", result, 16'd0);
        check("mid reset r", result2, 16'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        prev_q = '0;
        prev_r = '0;
        @(posedge clk);
        #1;
        wait_result("200/9 after reset", 16'd22, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inverse_kinematics.md
INVERSE_KINEMATICS -- requirements
Module: inverse_kinematics

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand and result bit width; all widths below are WIDTH.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port number, input, WIDTH, the unsigned dividend.
REQ-005 SHALL have port divisor, input, WIDTH, the unsigned divisor.
REQ-006 SHALL have port result, output, WIDTH, the registered quotient.
REQ-007 SHALL have port result2, output, WIDTH, the registered remainder.
REQ-008 SHALL use exactly this positional port order: clk, reset, number, divisor, result, result2.

Function
REQ-009 SHALL compute unsigned integer division number / divisor by an iterative radix-2 restoring algorithm, one quotient bit per clock.
REQ-010 SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-011 SHALL hold operand shadow registers; in IDLE, if number or divisor differs from its shadow copy, SHALL go to LOAD on the next edge.
REQ-012 In LOAD, SHALL capture number and divisor into the shadow and working registers and clear the partial remainder.
REQ-013 SHALL stay in RUN for exactly WIDTH cycles, processing the MSB first.
REQ-014 In each RUN cycle: shift the remainder left and bring in the next dividend bit; if remainder >= divisor, subtract and set the quotient bit, else set the quotient bit to 0.
REQ-015 In DONE (1 cycle), SHALL write result and result2, then return to IDLE.
REQ-016 Latency: the outputs update WIDTH+2 rising edges after the edge at which IDLE first sees changed operands; 18 cycles at default width.
REQ-017 result and result2 SHALL hold their last values at all times except the DONE write; there are no intermediate glitches.
REQ-018 If the inputs change during LOAD or RUN, SHALL abort the current operation without writing the outputs and go to LOAD on the next edge.
REQ-019 Divide-by-zero (divisor == 0) SHALL produce result = all ones (0xFFFF) and result2 = number, with normal latency.
REQ-020 number == 0 SHALL give result = 0 and result2 = 0 (when divisor != 0).
REQ-021 If the inputs are unchanged, SHALL stay in IDLE indefinitely without recomputing.

Reset
REQ-022 Asserting reset SHALL immediately force result = 0, result2 = 0, the state to IDLE and all working registers to 0, regardless of clk.
REQ-023 On reset, the shadow registers SHALL be set to all ones and a first-run flag SHALL be set, so the first IDLE cycle after release always enters LOAD.
REQ-024 Reset asserted during RUN SHALL discard the operation; no output is written.

Configuration
REQ-025 Macro INVERSE_KINEMATICS_ROUND_EN; when it is defined, DONE SHALL round result to nearest: if 2*remainder >= divisor, increment result, saturating at all ones.
REQ-026 When INVERSE_KINEMATICS_ROUND_EN is defined, result2 SHALL remain the true truncated remainder, and divide-by-zero behaviour is unchanged.
REQ-027 When INVERSE_KINEMATICS_ROUND_EN is not defined, result SHALL be the truncated quotient and no rounding logic SHALL be present.

Verification
REQ-028 Reset, release with number=9 and divisor=1 -> within 18 cycles result=9, result2=0.
REQ-029 After 100 cycles, set number=6 and divisor=2 -> exactly 18 cycles later result=3, result2=0, and the prior values are held until then.
REQ-030 number=8, divisor=5 -> result=1, result2=3; with INVERSE_KINEMATICS_ROUND_EN -> result=2, result2=3.
REQ-031 divisor=0, number=1234 -> result=0xFFFF, result2=1234.
REQ-032 Change the operands from 100/7 to 50/3 at cycle 5 of RUN -> the 100/7 result is never output; 18 cycles after the change result=16, result2=2.
REQ-033 Assert reset mid-RUN -> the outputs read 0 immediately, then the current operands are recomputed after release.
